// File: rtl/mux_pipe_n.sv
// mux_pipe_n: N:1 WIDTH-bit select stage with a two-entry skid-buffered valid/ready output
module mux_pipe_n #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t           state;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] skid_data;
    logic [SELW-1:0]  skid_sel;
    logic             bad;
    logic             accept;
    logic             consume;
    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;
    // pick the addressed channel; an index past the last channel yields zero and flags bad
    always_comb begin
        word = '0;
        bad  = 1'b1;
        for (int k = 0; k < N; k++)
            if (sel == SELW'(k)) begin
                word = in_data[k*WIDTH +: WIDTH];
                bad  = 1'b0;
            end
    end
    // occupancy FSM: main register drives the outputs, skid holds the second entry under stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            out_sel   <= '0;
            skid_data <= '0;
            skid_sel  <= '0;
            sel_err   <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            if (accept && bad) sel_err <= 1'b1;
            case (state)
                EMPTY: if (accept) begin
                    state     <= ONE;
                    out_valid <= 1'b1;
                    out_data  <= word;
                    out_sel   <= sel;
                end
                ONE: if (accept && consume) begin
                    out_data <= word;
                    out_sel  <= sel;
                end else if (accept) begin
                    state     <= TWO;
                    in_ready  <= 1'b0;
                    skid_data <= word;
                    skid_sel  <= sel;
                end else if (consume) begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
                TWO: if (consume) begin
                    state    <= ONE;
                    in_ready <= 1'b1;
                    out_data <= skid_data;
                    out_sel  <= skid_sel;
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_pipe_n.sv
// tb_mux_pipe_n: randomized and directed checks of mux_pipe_n against a queue model
module tb_mux_pipe_n;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_data;
    logic [1:0]  sel;
    logic        in_valid, in_ready, flush, out_valid, out_ready, sel_err;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic [23:0] b_in_data;
    logic [1:0]  b_sel, b_out_sel;
    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err;
    logic [7:0]  b_out_data;

    typedef struct packed {logic [7:0] d; logic [1:0] s;} ent_t;
    ent_t q[$];
    int checks = 0, errors = 0, accepted = 0, emitted = 0;

    always #5 clk = ~clk;

    mux_pipe_n #(.WIDTH(8), .N(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
    );

    mux_pipe_n #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_data(b_in_data), .sel(b_sel), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .flush(b_flush), .out_data(b_out_data), .out_sel(b_out_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .sel_err(b_sel_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        chk("sel_err", {63'd0, sel_err}, 64'd0);
        if (q.size() > 0) begin
            chk("out_data", {56'd0, out_data}, {56'd0, q[0].d});
            chk("out_sel", {62'd0, out_sel}, {62'd0, q[0].s});
        end
    endtask

    // one clock of the behavioural FIFO model (capacity two) followed by a full output check
    task automatic step();
        bit   acc, con;
        ent_t e;
        acc = in_valid && (q.size() < 2);
        con = out_ready && (q.size() > 0);
        e.d = 8'((in_data >> (32'(sel) * 8)) & 32'hFF);
        e.s = sel;
        @(posedge clk);
        #1;
        if (flush) q.delete();
        else begin
            if (con) begin void'(q.pop_front()); emitted++; end
            if (acc) begin q.push_back(e); accepted++; end
        end
        check_all();
    endtask

    task automatic offer(input logic [1:0] s, input logic [7:0] d);
        in_data = {4{8'h00}};
        in_data[8*s +: 8] = d;
        sel = s;
        in_valid = 1'b1;
    endtask

    initial begin
        logic [7:0] t1 [4];
        t1[0] = 8'hA0; t1[1] = 8'hB1; t1[2] = 8'hC2; t1[3] = 8'hD3;
        reset_n = 1'b0;
        in_data = '0; sel = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        b_in_data = '0; b_sel = '0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_data", {56'd0, out_data}, 64'd0);
        chk("rst_sel", {62'd0, out_sel}, 64'd0);
        chk("rst_err", {63'd0, sel_err}, 64'd0);
        chk("rst_err3", {63'd0, b_sel_err}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // streaming, full throughput
        in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
            chk("t1_data", {56'd0, out_data}, {56'd0, t1[i]});
            chk("t1_ready", {63'd0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        step();

        // back-pressure into the skid entry, then drain
        out_ready = 1'b0;
        offer(2'd0, 8'h11); step();
        offer(2'd1, 8'h22); step();
        chk("t2_full", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        in_data = '1;
        repeat (3) begin step(); chk("t2_hold", {56'd0, out_data}, 64'h11); end
        out_ready = 1'b1;
        step();
        chk("t2_second", {56'd0, out_data}, 64'h22);
        chk("t2_ready", {63'd0, in_ready}, 64'd1);
        step();

        // flush with two entries held and a word offered the same cycle
        out_ready = 1'b0;
        offer(2'd2, 8'h33); step();
        offer(2'd3, 8'h44); step();
        offer(2'd1, 8'h77);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("t4_valid", {63'd0, out_valid}, 64'd0);
        chk("t4_ready", {63'd0, in_ready}, 64'd1);
        repeat (3) step();

        // asynchronous reset while two entries are held
        out_ready = 1'b0;
        offer(2'd0, 8'h55); step();
        offer(2'd1, 8'h66); step();
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_ready", {63'd0, in_ready}, 64'd1);
        chk("t5_data", {56'd0, out_data}, 64'd0);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        offer(2'd2, 8'h5A);
        step();
        chk("t5_first", {56'd0, out_data}, 64'h5A);
        in_valid = 1'b0;
        step();

        // random traffic
        accepted = 0;
        emitted = 0;
        for (int i = 0; i < 10000; i++) begin
            in_data = $urandom;
            sel = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("t6_count", 64'(emitted), 64'(accepted));

        // out-of-range select on the three-channel instance
        b_in_data = {8'hC2, 8'hB1, 8'hA0};
        b_sel = 2'd3;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        chk("t3_valid", {63'd0, b_out_valid}, 64'd1);
        chk("t3_zero", {56'd0, b_out_data}, 64'd0);
        chk("t3_sel", {62'd0, b_out_sel}, 64'd3);
        chk("t3_err", {63'd0, b_sel_err}, 64'd1);
        b_sel = 2'd1;
        @(posedge clk); #1;
        chk("t3_data", {56'd0, b_out_data}, 64'hB1);
        chk("t3_sel1", {62'd0, b_out_sel}, 64'd1);
        chk("t3_sticky", {63'd0, b_sel_err}, 64'd1);
        b_in_valid = 1'b0;
        b_flush = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0;
        chk("t3_flush_valid", {63'd0, b_out_valid}, 64'd0);
        chk("t3_flush_err", {63'd0, b_sel_err}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_pipe_n.md
Name: mux_pipe_n

Overview:
Parametrised N:1, WIDTH-bit multiplexer with a registered, back-pressure-aware output stage. It generalises the two-input single-bit selector to N channels of WIDTH bits and adds a valid/ready handshake on both sides. A two-entry skid buffer allows full throughput under stall. It serves as the operand/forwarding select stage between pipeline registers, where the downstream stage may stall or be flushed.

Parameters:
WIDTH, 64, data bits per channel
N, 4, number of input channels (>=2; need not be a power of two)
SELW, $clog2(N), select width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
sel  input  SELW  channel index, sampled with in_data on accept
in_valid  input  1  upstream offers in_data/sel
in_ready  output  1  block can accept this cycle
flush  input  1  synchronous discard of all buffered entries
out_data  output  WIDTH  selected word, registered
out_sel  output  SELW  sel value that produced out_data
out_valid  output  1  out_data valid
out_ready  input  1  downstream consumes when out_valid&&out_ready
sel_err  output  1  sticky: an accepted sel was >= N

Behaviour:
- Reset (reset_n=0, asynchronous): state EMPTY; out_valid=0, out_data=0, out_sel=0, sel_err=0, in_ready=1, skid register=0. Release is synchronous to clk.
- accept = in_valid && in_ready; consume = out_valid && out_ready.
- Selected word = in_data[sel*WIDTH +: WIDTH] when sel<N. When sel>=N (N not a power of two): word = 0 and sel_err set to 1 on that edge; it remains 1 until reset. The transfer itself still completes.
- in_ready = (state != TWO). It is driven from the state register only, with no combinational path from out_ready.
- Latency: an accepted word appears on out_data/out_valid on the next edge when the buffer is empty.
- Throughput: one word per cycle when out_ready is held at 1.
- States (number of held entries):
  EMPTY: accept -> ONE (main <= word).
  ONE: accept && consume -> ONE (main <= word). accept && !consume -> TWO (skid <= word). !accept && consume -> EMPTY. Otherwise hold.
  TWO: consume -> ONE (main <= skid). Otherwise hold. No accept is possible in TWO.
- Ordering: strictly FIFO. The skid entry is never output before the main entry.
- Stability: while out_valid=1 && out_ready=0, out_data and out_sel must not change.
- flush=1: on the edge the state becomes EMPTY and out_valid=0; any same-cycle accept is dropped. flush has priority over accept and consume. sel_err is unaffected. out_data/out_sel may retain stale values.
- in_valid is not required to stay high. Dropping it without acceptance is legal.
- Reset mid-transfer: all entries are lost immediately and outputs return to reset values asynchronously.

Test Plan:
1. WIDTH=8, N=4. Hold out_ready=1 and stream sel=0,1,2,3 with channels {8'hA0,8'hB1,8'hC2,8'hD3}, in_valid=1 -> out_data A0,B1,C2,D3 on consecutive cycles one cycle later. out_sel=0..3. in_ready stays 1.
2. Back-pressure: out_ready=0, send words 11 then 22 -> state TWO and in_ready=0 after the second accept, with out_data=11 held stable. Raise out_ready -> 11 then 22 are emitted and in_ready returns to 1 after the first consume.
3. N=3, SELW=2: accept sel=3 -> out_data=0, sel_err=1. A following valid sel=1 transfers normally and sel_err stays 1.
4. With two entries buffered, assert flush with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the offered word is never emitted.
5. Drop reset_n to 0 mid-cycle while state is TWO -> out_valid=0 and in_ready=1 without waiting for a clk edge. After release, first accepted word 5A appears after 1 cycle.
6. Random in_valid/out_ready at 50% for 10k cycles -> scoreboard shows every accepted word emitted exactly once, in order, with out_sel matching its sel.
